bram_fill_ctrl: RTL and testbench

- Upstream stage of the block-RAM write path.
- Accepts a byte stream over a valid/ready handshake after a `start` pulse.
- Assigns sequential addresses 0..DEPTH-1 and drives the registered `en`/`addr`/`data` triple into the BRAM writer stage.
- Reports progress, a running XOR checksum and a one-cycle `done` when the frame is complete.

---
 rtl/bram_fill_ctrl_pkg.sv | 23 ++
 rtl/bram_fill_ctrl.sv | 150 +++++++++++++++
 tb/tb_bram_fill_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_fill_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bram_fill_ctrl_pkg
//   Shared constants for the block-RAM write path: frame geometry and the
//   state encoding of the fill controller. The writer and reader stages
//   import the same package so that all of them agree on DEPTH, ADDR_W and
//   DATA_W.
// -----------------------------------------------------------------------------
package bram_fill_ctrl_pkg;

  // Frame geometry. BFC_DEPTH must equal 2**BFC_ADDR_W so that the write
  // pointer wraps to 0 exactly at the end of a frame.
  localparam int BFC_ADDR_W = 3;
  localparam int BFC_DEPTH  = 8;
  localparam int BFC_DATA_W = 8;

  // Fill controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_t;

endpackage

// File: rtl/bram_fill_ctrl.sv
// -----------------------------------------------------------------------------
// bram_fill_ctrl
//   Upstream stage of the block-RAM write path. After a start pulse it
//   accepts DEPTH bytes over a valid/ready handshake, gives them sequential
//   addresses 0..DEPTH-1 and presents a registered en/addr/data triple to
//   the BRAM writer one cycle after each accept. It also reports the byte
//   count and running XOR checksum of the frame and pulses done for one
//   cycle when the frame completes. An abort drops the frame without done.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     frame start request, only honoured in IDLE
//   abort     cancel current frame (wins over start in IDLE)
//   s_valid   input byte valid
//   s_data    input byte
//   s_ready   byte accepted this cycle if s_valid is high
//   wr_en     write strobe to BRAM writer
//   wr_addr   write address
//   wr_data   write data
//   wr_count  bytes accepted in current/last frame (0..DEPTH)
//   csum      XOR of bytes accepted in current/last frame
//   busy      high while filling
//   done      one-cycle pulse on frame completion
// -----------------------------------------------------------------------------
module bram_fill_ctrl
  import bram_fill_ctrl_pkg::*;
#(
  parameter int DEPTH  = BFC_DEPTH,
  parameter int ADDR_W = BFC_ADDR_W,
  parameter int DATA_W = BFC_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W:0]   wr_count,
  output logic [DATA_W-1:0] csum,
  output logic              busy,
  output logic              done
);

  fill_state_t       r_state;
  fill_state_t       w_state_nxt;

  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_csum;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  logic              w_s_ready;
  logic              w_accept;
  logic              w_last;
  logic              w_start_frame;

  // Ready is a pure function of the state register and abort, so an abort
  // cycle never accepts the byte that is presented alongside it.
  assign w_s_ready     = (r_state == ST_FILL) && !abort;
  assign w_accept      = s_valid && w_s_ready;
  assign w_last        = (r_ptr == ADDR_W'(DEPTH - 1));
  assign w_start_frame = (r_state == ST_IDLE) && start && !abort;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. DONE is a single-cycle state and always falls back
  // to IDLE, so a start seen there is dropped.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_frame) begin
          w_state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_accept && w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Pointer, count and checksum clear on frame start and advance on each
  // accept. They are left untouched on abort so the partial values remain
  // visible. The pointer wraps to 0 naturally after the DEPTH-th byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_csum  <= '0;
    end else if (w_start_frame) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_csum  <= '0;
    end else if (w_accept) begin
      r_ptr   <= r_ptr + ADDR_W'(1);
      r_count <= r_count + (ADDR_W + 1)'(1);
      r_csum  <= r_csum ^ s_data;
    end
  end

  // Write-side output registers: strobe is the registered accept, address
  // and data capture on accept and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= s_data;
      end
    end
  end

  assign s_ready  = w_s_ready;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign wr_count = r_count;
  assign csum     = r_csum;
  assign busy     = (r_state == ST_FILL);
  assign done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_bram_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bram_fill_ctrl
//   Self-checking bench for bram_fill_ctrl. Expected write strobes are pushed
//   to a scoreboard queue when a byte is presented that the bench expects
//   to be accepted, and popped by a monitor when the DUT strobes. Status
//   outputs are checked inline by each scenario task.
// -----------------------------------------------------------------------------
module tb_bram_fill_ctrl;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;

  typedef struct {
    int                due;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_wr_t;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]   wr_count;
  logic [DATA_W-1:0] csum;
  logic              busy;
  logic              done;

  exp_wr_t           scb[$];
  int                cyc;
  int                vectors;
  int                miscompares;
  logic [ADDR_W-1:0] expPtr;
  logic [DATA_W-1:0] expCsum;
  int                expCount;

  bram_fill_ctrl #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_count(wr_count),
    .csum    (csum),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: every strobe must match the head of the scoreboard in
  // address, data and the cycle it was due; a due entry with no strobe is
  // a missed write.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      vectors++;
      if (scb.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_strobe cyc=%0d addr=%0d data=%h", cyc, wr_addr, wr_data);
      end else begin
        if (scb[0].due != cyc || scb[0].addr !== wr_addr || scb[0].data !== wr_data) begin
          miscompares++;
          $display("[TB] FAIL strobe cyc=%0d got addr=%0d data=%h, want cyc=%0d addr=%0d data=%h",
                   cyc, wr_addr, wr_data, scb[0].due, scb[0].addr, scb[0].data);
        end
        void'(scb.pop_front());
      end
    end else if (wr_en !== 1'b0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL wr_en_unknown cyc=%0d got %b want 0/1", cyc, wr_en);
    end else if (scb.size() != 0 && scb[0].due <= cyc) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL missed_strobe cyc=%0d got wr_en=0, want addr=%0d data=%h",
               cyc, scb[0].addr, scb[0].data);
      void'(scb.pop_front());
    end
  end

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a byte the bench expects to be accepted on the next edge and
  // record the strobe and model updates it should produce.
  task automatic pushByte(input logic [DATA_W-1:0] b);
    exp_wr_t e;
    s_valid = 1'b1;
    s_data  = b;
    e.due   = cyc + 1;
    e.addr  = expPtr;
    e.data  = b;
    scb.push_back(e);
    expPtr   = expPtr + 1'b1;
    expCsum  = expCsum ^ b;
    expCount = expCount + 1;
  endtask

  task automatic beginFrame();
    start = 1'b1;
    tick();
    start    = 1'b0;
    expPtr   = '0;
    expCsum  = '0;
    expCount = 0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) tick();
    vectors++;
    if ({s_ready, wr_en, wr_addr, wr_data, wr_count, csum, busy, done} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got rdy=%b en=%b a=%0d d=%h cnt=%0d cs=%h busy=%b done=%b, want all 0",
               s_ready, wr_en, wr_addr, wr_data, wr_count, csum, busy, done);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic expDone;
    beginFrame();
    vectors++;
    if (busy !== 1'b1 || s_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_start busy=%b s_ready=%b, want 1/1", busy, s_ready);
    end
    for (int i = 0; i < DEPTH; i++) begin
      pushByte(DATA_W'((i + 1) * 8'h11));
      tick();
      expDone = (i == DEPTH - 1);
      vectors++;
      if (done !== expDone) begin
        miscompares++;
        $display("[TB] FAIL b2b_done byte=%0d got %b want %b", i, done, expDone);
      end
    end
    s_valid = 1'b0;
    vectors++;
    if (wr_count !== (ADDR_W + 1)'(expCount) || csum !== expCsum || busy !== 1'b0 || s_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_final cnt=%0d cs=%h busy=%b rdy=%b, want %0d %h 0 0",
               wr_count, csum, busy, s_ready, expCount, expCsum);
    end
    vectors++;
    if (csum !== 8'h88) begin
      miscompares++;
      $display("[TB] FAIL b2b_csum_const got %h want 88", csum);
    end
    tick();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_done_width got %b want 0", done);
    end
    tick();
  endtask

  task automatic test_gapped();
    int   nAcc;
    int   doneCycles;
    logic expDone;
    beginFrame();
    nAcc       = 0;
    doneCycles = 0;
    for (int i = 0; i < 2 * DEPTH + 1; i++) begin
      expDone = 1'b0;
      if ((i % 2 == 0) && nAcc < DEPTH) begin
        pushByte(DATA_W'(8'hA0 + nAcc));
        nAcc++;
        expDone = (nAcc == DEPTH);
      end else begin
        s_valid = 1'b0;
        s_data  = 8'hEE;
      end
      tick();
      if (done === 1'b1) doneCycles++;
      vectors++;
      if (done !== expDone) begin
        miscompares++;
        $display("[TB] FAIL gap_done step=%0d got %b want %b", i, done, expDone);
      end
    end
    s_valid = 1'b0;
    vectors++;
    if (doneCycles != 1 || wr_count !== (ADDR_W + 1)'(expCount) || csum !== expCsum) begin
      miscompares++;
      $display("[TB] FAIL gap_final donecycles=%0d cnt=%0d cs=%h, want 1 %0d %h",
               doneCycles, wr_count, csum, expCount, expCsum);
    end
    tick();
  endtask

  task automatic test_abort();
    beginFrame();
    for (int i = 1; i <= 3; i++) begin
      pushByte(DATA_W'(i));
      tick();
    end
    s_valid = 1'b1;
    s_data  = 8'h04;
    abort   = 1'b1;
    #1;
    vectors++;
    if (s_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_ready got %b want 0", s_ready);
    end
    tick();
    abort   = 1'b0;
    s_valid = 1'b0;
    vectors++;
    if (busy !== 1'b0 || wr_count !== 4'd3 || csum !== expCsum) begin
      miscompares++;
      $display("[TB] FAIL abort_state busy=%b cnt=%0d cs=%h, want 0 3 %h", busy, wr_count, csum, expCsum);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL abort_done step=%0d got %b want 0", i, done);
      end
      tick();
    end
  endtask

  task automatic test_start_ignored();
    beginFrame();
    for (int i = 0; i < DEPTH; i++) begin
      start = (i == 2 || i == 5);
      pushByte(DATA_W'(8'h30 + i));
      tick();
    end
    s_valid = 1'b0;
    start   = 1'b1;
    vectors++;
    if (done !== 1'b1 || wr_count !== 4'd8 || csum !== expCsum) begin
      miscompares++;
      $display("[TB] FAIL ign_frame done=%b cnt=%0d cs=%h, want 1 8 %h", done, wr_count, csum, expCsum);
    end
    tick();
    start = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0 || wr_count !== 4'd8) begin
      miscompares++;
      $display("[TB] FAIL ign_done_start busy=%b cnt=%0d, want 0 8", busy, wr_count);
    end
    beginFrame();
    vectors++;
    if (busy !== 1'b1 || wr_count !== 4'd0 || csum !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL restart_clear busy=%b cnt=%0d cs=%h, want 1 0 00", busy, wr_count, csum);
    end
    pushByte(8'h5A);
    tick();
    s_valid = 1'b0;
    vectors++;
    if (wr_count !== 4'd1 || csum !== 8'h5A) begin
      miscompares++;
      $display("[TB] FAIL restart_byte cnt=%0d cs=%h, want 1 5a", wr_count, csum);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic test_reset_midframe();
    beginFrame();
    for (int i = 0; i < 4; i++) begin
      pushByte(DATA_W'(8'h60 + i));
      tick();
    end
    s_valid = 1'b1;
    s_data  = 8'h64;
    #2;
    rst_n = 1'b0;
    scb.delete();
    #1;
    vectors++;
    if ({s_ready, wr_en, wr_addr, wr_data, wr_count, csum, busy, done} !== '0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid got rdy=%b en=%b a=%0d d=%h cnt=%0d cs=%h busy=%b done=%b, want all 0",
               s_ready, wr_en, wr_addr, wr_data, wr_count, csum, busy, done);
    end
    repeat (2) tick();
    s_valid = 1'b0;
    rst_n   = 1'b1;
    tick();
    beginFrame();
    for (int i = 0; i < DEPTH; i++) begin
      pushByte(DATA_W'(8'hC0 ^ i));
      tick();
    end
    s_valid = 1'b0;
    vectors++;
    if (done !== 1'b1 || wr_count !== 4'd8 || csum !== expCsum) begin
      miscompares++;
      $display("[TB] FAIL rst_refill done=%b cnt=%0d cs=%h, want 1 8 %h", done, wr_count, csum, expCsum);
    end
    tick();
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start   = 1'b0;
    abort   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h99;
    vectors++;
    if (busy !== 1'b0 || s_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL start_abort busy=%b s_ready=%b, want 0 0", busy, s_ready);
    end
    repeat (2) tick();
    s_valid = 1'b0;
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    expPtr      = '0;
    expCsum     = '0;
    expCount    = 0;
    test_reset();
    test_back_to_back();
    test_gapped();
    test_abort();
    test_start_ignored();
    test_reset_midframe();
    test_start_abort_idle();
    repeat (2) tick();
    vectors++;
    if (scb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain got %0d pending, want 0", scb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
